// File: rtl/spr_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : spr_writeback_if
// Purpose  : Bundles the SPR result bus, the commit report channel and the
//            mfspr read port of spr_writeback.
// Revision : 1.0 - initial release
// ============================================================================
interface spr_writeback_if #(
  parameter int RS_ID_WIDTH = 5
);
  logic                   spr_in_valid;
  logic                   spr_in_ready;
  logic [RS_ID_WIDTH-1:0] spr_in_rs_id;
  logic [9:0]             spr_in_addr;
  logic [31:0]            spr_in_data;
  logic                   done_valid;
  logic                   done_ready;
  logic [RS_ID_WIDTH-1:0] done_rs_id;
  logic                   done_error;
  logic [9:0]             rd_addr;
  logic [31:0]            rd_data;
  logic                   rd_hazard;

  // Write-back block side
  modport slave (
    input  spr_in_valid, spr_in_rs_id, spr_in_addr, spr_in_data,
    input  done_ready, rd_addr,
    output spr_in_ready, done_valid, done_rs_id, done_error, rd_data, rd_hazard
  );

  // Execution unit / completion logic side
  modport master (
    output spr_in_valid, spr_in_rs_id, spr_in_addr, spr_in_data,
    output done_ready, rd_addr,
    input  spr_in_ready, done_valid, done_rs_id, done_error, rd_data, rd_hazard
  );
endinterface
`default_nettype wire

// File: rtl/spr_writeback.sv
`default_nettype none
// ============================================================================
// Module   : spr_writeback
// Purpose  : Buffers mtspr results in a small FIFO, commits them in order into
//            the architected SPRs, reports each commit, and offers a
//            combinational read port with a pending-write hazard flag.
// Revision : 1.0 - initial release
// ============================================================================
module spr_writeback #(
  parameter int          RS_ID_WIDTH = 5,
  parameter int          FIFO_DEPTH  = 2,
  parameter logic [31:0] PVR_VALUE   = 32'h0001_0000
) (
  input  logic            clk,
  input  logic            rst,   // asynchronous, active-low
  spr_writeback_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [9:0] C_XER   = 10'd1;
  localparam logic [9:0] C_LR    = 10'd8;
  localparam logic [9:0] C_CTR   = 10'd9;
  localparam logic [9:0] C_SRR0  = 10'd26;
  localparam logic [9:0] C_SRR1  = 10'd27;
  localparam logic [9:0] C_SPRG0 = 10'd272;
  localparam logic [9:0] C_SPRG1 = 10'd273;
  localparam logic [9:0] C_SPRG2 = 10'd274;
  localparam logic [9:0] C_SPRG3 = 10'd275;
  localparam logic [9:0] C_PVR   = 10'd287;

  // FIFO storage and control
  logic [RS_ID_WIDTH-1:0] fifo_rs_q   [FIFO_DEPTH];
  logic [9:0]             fifo_addr_q [FIFO_DEPTH];
  logic [31:0]            fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q, count_d;

  // Architected SPRs
  logic [31:0] xer_q, lr_q, ctr_q, srr0_q, srr1_q;
  logic [31:0] sprg_q [4];

  // Commit report
  logic                   done_valid_q;
  logic [RS_ID_WIDTH-1:0] done_rs_id_q;
  logic                   done_error_q;

  logic full, empty, push, pop, head_err;
  logic [9:0]  head_addr;
  logic [31:0] head_data;

  // Writable SPR numbers; PVR and everything else are rejected
  function automatic logic is_writable(input logic [9:0] a);
    case (a)
      C_XER, C_LR, C_CTR, C_SRR0, C_SRR1,
      C_SPRG0, C_SPRG1, C_SPRG2, C_SPRG3: is_writable = 1'b1;
      default:                            is_writable = 1'b0;
    endcase
  endfunction

  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign push      = bus.spr_in_valid && !full;
  assign pop       = !empty && (!done_valid_q || bus.done_ready);
  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];
  assign head_err  = !is_writable(head_addr);

  assign bus.spr_in_ready = !full;
  assign bus.done_valid   = done_valid_q;
  assign bus.done_rs_id   = done_rs_id_q;
  assign bus.done_error   = done_error_q;

  // Occupancy next state: simultaneous push and pop leave it unchanged
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // FIFO pointers and occupancy; reset discards any buffered entries
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // FIFO payload; contents are only meaningful where the count says so
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rs_q[wr_ptr_q]   <= bus.spr_in_rs_id;
      fifo_addr_q[wr_ptr_q] <= bus.spr_in_addr;
      fifo_data_q[wr_ptr_q] <= bus.spr_in_data;
    end
  end

  // Commit the head entry into its SPR when it pops and the address is legal
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xer_q  <= '0;
      lr_q   <= '0;
      ctr_q  <= '0;
      srr0_q <= '0;
      srr1_q <= '0;
      for (int i = 0; i < 4; i++) sprg_q[i] <= '0;
    end else if (pop && !head_err) begin
      case (head_addr)
        C_XER:   xer_q     <= head_data;
        C_LR:    lr_q      <= head_data;
        C_CTR:   ctr_q     <= head_data;
        C_SRR0:  srr0_q    <= head_data;
        C_SRR1:  srr1_q    <= head_data;
        C_SPRG0: sprg_q[0] <= head_data;
        C_SPRG1: sprg_q[1] <= head_data;
        C_SPRG2: sprg_q[2] <= head_data;
        C_SPRG3: sprg_q[3] <= head_data;
        default: ;
      endcase
    end
  end

  // Commit report: load on pop, drop once accepted with nothing left to pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_valid_q <= 1'b0;
      done_rs_id_q <= '0;
      done_error_q <= 1'b0;
    end else if (pop) begin
      done_valid_q <= 1'b1;
      done_rs_id_q <= fifo_rs_q[rd_ptr_q];
      done_error_q <= head_err;
    end else if (bus.done_ready) begin
      done_valid_q <= 1'b0;
    end
  end

  // Read port straight from architected storage, never from the FIFO
  always_comb begin
    case (bus.rd_addr)
      C_XER:   bus.rd_data = xer_q;
      C_LR:    bus.rd_data = lr_q;
      C_CTR:   bus.rd_data = ctr_q;
      C_SRR0:  bus.rd_data = srr0_q;
      C_SRR1:  bus.rd_data = srr1_q;
      C_SPRG0: bus.rd_data = sprg_q[0];
      C_SPRG1: bus.rd_data = sprg_q[1];
      C_SPRG2: bus.rd_data = sprg_q[2];
      C_SPRG3: bus.rd_data = sprg_q[3];
      C_PVR:   bus.rd_data = PVR_VALUE;
      default: bus.rd_data = 32'h0;
    endcase
  end

  // Hazard: any occupied slot (offset from head below count) targeting rd_addr
  always_comb begin
    logic [PTR_W-1:0] off;
    bus.rd_hazard = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && (fifo_addr_q[i] == bus.rd_addr))
        bus.rd_hazard = 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_spr_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_spr_writeback
// Purpose  : Directed self-checking bench for spr_writeback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spr_writeback;
  localparam logic [31:0] PVR = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  spr_writeback_if #(.RS_ID_WIDTH(5)) bus ();

  spr_writeback #(.RS_ID_WIDTH(5), .FIFO_DEPTH(2), .PVR_VALUE(PVR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one write for one accepting edge; returns 1 time unit after it
  task automatic push(input logic [4:0] id, input logic [9:0] addr, input logic [31:0] data);
    for (int k = 0; k < 20 && !bus.spr_in_ready; k++) tick();
    if (!bus.spr_in_ready) chk("push_ready_timeout", 32'(bus.spr_in_ready), 32'd1);
    bus.spr_in_valid = 1'b1;
    bus.spr_in_rs_id = id;
    bus.spr_in_addr  = addr;
    bus.spr_in_data  = data;
    tick();
    bus.spr_in_valid = 1'b0;
  endtask

  initial begin
    bus.spr_in_valid = 1'b0;
    bus.spr_in_rs_id = '0;
    bus.spr_in_addr  = '0;
    bus.spr_in_data  = '0;
    bus.done_ready   = 1'b1;
    bus.rd_addr      = 10'd8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Reset state
    chk("rst_ready",      32'(bus.spr_in_ready), 32'd1);
    chk("rst_done_valid", 32'(bus.done_valid),   32'd0);
    chk("rst_done_rs_id", 32'(bus.done_rs_id),   32'd0);
    chk("rst_done_error", 32'(bus.done_error),   32'd0);
    chk("rst_lr",         bus.rd_data,           32'd0);

    // Single write to LR
    push(5'd3, 10'd8, 32'hDEAD_BEEF);
    chk("single_hazard_e0", 32'(bus.rd_hazard), 32'd1);
    chk("single_old_lr",    bus.rd_data,        32'd0);
    tick();
    chk("single_done_valid", 32'(bus.done_valid), 32'd1);
    chk("single_done_rs_id", 32'(bus.done_rs_id), 32'd3);
    chk("single_done_error", 32'(bus.done_error), 32'd0);
    chk("single_lr",         bus.rd_data,         32'hDEAD_BEEF);
    chk("single_hazard_e1",  32'(bus.rd_hazard),  32'd0);
    tick();
    chk("single_done_drop", 32'(bus.done_valid), 32'd0);

    // Backpressure on CTR
    bus.done_ready = 1'b0;
    bus.rd_addr    = 10'd9;
    push(5'd10, 10'd9, 32'd1);
    push(5'd11, 10'd9, 32'd2);
    push(5'd12, 10'd9, 32'd3);
    chk("bp_ready_full", 32'(bus.spr_in_ready), 32'd0);
    chk("bp_done_valid", 32'(bus.done_valid),   32'd1);
    chk("bp_done_rs_id", 32'(bus.done_rs_id),   32'd10);
    chk("bp_ctr_first",  bus.rd_data,           32'd1);
    tick();
    tick();
    chk("bp_hold_rs_id", 32'(bus.done_rs_id), 32'd10);
    chk("bp_hold_valid", 32'(bus.done_valid), 32'd1);
    bus.done_ready = 1'b1;
    tick();
    chk("bp_rel1_rs_id", 32'(bus.done_rs_id),   32'd11);
    chk("bp_rel1_ctr",   bus.rd_data,           32'd2);
    chk("bp_rel1_ready", 32'(bus.spr_in_ready), 32'd1);
    tick();
    chk("bp_rel2_rs_id", 32'(bus.done_rs_id), 32'd12);
    chk("bp_rel2_ctr",   bus.rd_data,         32'd3);
    tick();
    chk("bp_drain_valid", 32'(bus.done_valid), 32'd0);

    // Illegal writes: read-only PVR and an unimplemented SPR
    push(5'd20, 10'd287, 32'd5);
    push(5'd21, 10'd100, 32'd7);
    chk("ill_pvr_rs_id", 32'(bus.done_rs_id), 32'd20);
    chk("ill_pvr_error", 32'(bus.done_error), 32'd1);
    tick();
    chk("ill_100_rs_id", 32'(bus.done_rs_id), 32'd21);
    chk("ill_100_error", 32'(bus.done_error), 32'd1);
    bus.rd_addr = 10'd287;
    #1 chk("ill_rd_pvr", bus.rd_data, PVR);
    bus.rd_addr = 10'd100;
    #1 chk("ill_rd_100", bus.rd_data, 32'd0);
    tick();

    // Hazard on SRR0 while buffered
    bus.rd_addr = 10'd26;
    push(5'd1, 10'd26, 32'h0000_1111);
    tick();
    chk("hz_srr0_old", bus.rd_data, 32'h0000_1111);
    tick();
    bus.done_ready = 1'b0;
    push(5'd2, 10'd272, 32'h0000_00AA);
    push(5'd4, 10'd26,  32'h0000_2222);
    chk("hz_pending",    32'(bus.rd_hazard), 32'd1);
    chk("hz_stale_data", bus.rd_data,        32'h0000_1111);
    bus.done_ready = 1'b1;
    tick();
    chk("hz_cleared",   32'(bus.rd_hazard), 32'd0);
    chk("hz_new_data",  bus.rd_data,        32'h0000_2222);
    chk("hz_done_rs_id", 32'(bus.done_rs_id), 32'd4);
    tick();

    // Streaming 16 writes to SPRG3
    bus.rd_addr      = 10'd275;
    bus.spr_in_valid = 1'b1;
    bus.spr_in_rs_id = 5'd0;
    bus.spr_in_addr  = 10'd275;
    bus.spr_in_data  = 32'd0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("stream_ready", 32'(bus.spr_in_ready), 32'd1);
      if (i > 0) begin
        chk("stream_done_valid", 32'(bus.done_valid), 32'd1);
        chk("stream_done_rs_id", 32'(bus.done_rs_id), 32'(i - 1));
      end
      if (i < 15) begin
        bus.spr_in_rs_id = 5'(i + 1);
        bus.spr_in_data  = 32'(i + 1);
      end else begin
        bus.spr_in_valid = 1'b0;
      end
    end
    tick();
    chk("stream_last_rs_id", 32'(bus.done_rs_id), 32'd15);
    chk("stream_sprg3",      bus.rd_data,         32'd15);
    tick();

    // Asynchronous reset with two entries buffered
    bus.done_ready = 1'b0;
    bus.rd_addr    = 10'd8;
    push(5'd5, 10'd273, 32'd1);
    push(5'd6, 10'd8,   32'h0000_1234);
    push(5'd7, 10'd274, 32'd2);
    chk("mr_full",   32'(bus.spr_in_ready), 32'd0);
    chk("mr_hazard", 32'(bus.rd_hazard),    32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mr_ready",      32'(bus.spr_in_ready), 32'd1);
    chk("mr_done_valid", 32'(bus.done_valid),   32'd0);
    chk("mr_done_rs_id", 32'(bus.done_rs_id),   32'd0);
    chk("mr_lr",         bus.rd_data,           32'd0);
    chk("mr_hazard_clr", 32'(bus.rd_hazard),    32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("mr_post_valid", 32'(bus.done_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
